// File: rtl/dst_pkg.sv
// Shared constants for the 4x4 DST-VII engines: transform matrix,
// default widths/shifts and the sequencer state encoding.
package dst_pkg;

    localparam int DEF_IN_W    = 16;
    localparam int DEF_COEFF_W = 8;
    localparam int DEF_MID_W   = 20;
    localparam int DEF_OUT_W   = 16;
    localparam int DEF_SHIFT1  = 7;
    localparam int DEF_SHIFT2  = 12;

    // Forward DST-VII basis, row-major; the inverse uses its transpose.
    localparam logic signed [DEF_COEFF_W-1:0] DST4_M [4][4] = '{
        '{ 8'sd29,  8'sd55,  8'sd74,  8'sd84},
        '{ 8'sd74,  8'sd74,  8'sd0,  -8'sd74},
        '{ 8'sd84, -8'sd29, -8'sd74,  8'sd55},
        '{ 8'sd55, -8'sd84,  8'sd74, -8'sd29}
    };

    typedef enum logic [1:0] {
        ST_LOAD,
        ST_PASS1,
        ST_OUT
    } fsm_state_t;

endpackage

// File: rtl/idst4_1d.sv
// Combinational 4-point inverse DST-VII: dout[n] = clip((sum_k M[k][n]*din[k]
// + round) >>> SHIFT). Used for both the column and the row pass.
module idst4_1d
    import dst_pkg::*;
#(
    parameter int IN_BITS    = DEF_IN_W,
    parameter int COEFF_BITS = DEF_COEFF_W,
    parameter int OUT_BITS   = DEF_MID_W,
    parameter int SHIFT      = DEF_SHIFT1
) (
    input  logic [4*IN_BITS-1:0]  din,
    output logic [4*OUT_BITS-1:0] dout
);

    // Four products plus rounding need IN+COEFF+2 bits; one spare bit of headroom.
    localparam int ACC_W = IN_BITS + COEFF_BITS + 3;

    localparam logic signed [ACC_W-1:0] ROUND = ACC_W'(2 ** (SHIFT - 1));
    localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(2 ** (OUT_BITS - 1) - 1);
    localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(-(2 ** (OUT_BITS - 1)));

    // Dot product, rounding floor shift and saturation for each output point.
    always_comb begin
        logic signed [ACC_W-1:0] acc;
        logic signed [ACC_W-1:0] val;
        acc  = '0;
        val  = '0;
        dout = '0;
        for (int unsigned n = 0; n < 4; n++) begin
            acc = ROUND;
            for (int unsigned k = 0; k < 4; k++) begin
                acc = acc + ACC_W'(signed'(din[k*IN_BITS +: IN_BITS])) * ACC_W'(DST4_M[k][n]);
            end
            val = acc >>> SHIFT;
            if (val > MAX_V) begin
                val = MAX_V;
            end else if (val < MIN_V) begin
                val = MIN_V;
            end
            dout[n*OUT_BITS +: OUT_BITS] = OUT_BITS'(val);
        end
    end

endmodule

// File: rtl/idst4x4_seq.sv
// Sequential 4x4 inverse DST-VII: loads four coefficient rows, runs the
// column pass one column per cycle into T, then streams the row pass out.
module idst4x4_seq
    import dst_pkg::*;
#(
    parameter int IN_W    = DEF_IN_W,
    parameter int COEFF_W = DEF_COEFF_W,
    parameter int MID_W   = DEF_MID_W,
    parameter int OUT_W   = DEF_OUT_W,
    parameter int SHIFT1  = DEF_SHIFT1,
    parameter int SHIFT2  = DEF_SHIFT2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [4*IN_W-1:0]   s_row,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [4*OUT_W-1:0]  m_row,
    output logic                m_last
);

    fsm_state_t         state;
    logic [1:0]         row_cnt;
    logic [1:0]         col_cnt;

    logic [4*IN_W-1:0]  y_buf [4];
    logic [MID_W-1:0]   t_buf [4][4];

    logic [4*IN_W-1:0]  p1_in;
    logic [4*MID_W-1:0] p1_out;
    logic [1:0]         p2_sel;
    logic [4*MID_W-1:0] p2_in;
    logic [4*OUT_W-1:0] p2_out;

    // Gather column col_cnt of Y for the column pass.
    always_comb begin
        p1_in = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            p1_in[k*IN_W +: IN_W] = y_buf[k][col_cnt*IN_W +: IN_W];
        end
    end

    idst4_1d #(
        .IN_BITS   (IN_W),
        .COEFF_BITS(COEFF_W),
        .OUT_BITS  (MID_W),
        .SHIFT     (SHIFT1)
    ) u_pass1 (
        .din (p1_in),
        .dout(p1_out)
    );

    // Row pass computes the row that will be registered next: the current
    // row while nothing is presented yet, otherwise its successor.
    always_comb begin
        p2_sel = m_valid ? row_cnt + 2'd1 : row_cnt;
        p2_in  = '0;
        for (int unsigned k = 0; k < 4; k++) begin
            p2_in[k*MID_W +: MID_W] = t_buf[p2_sel][k];
        end
    end

    idst4_1d #(
        .IN_BITS   (MID_W),
        .COEFF_BITS(COEFF_W),
        .OUT_BITS  (OUT_W),
        .SHIFT     (SHIFT2)
    ) u_pass2 (
        .din (p2_in),
        .dout(p2_out)
    );

    // Data buffers: capture accepted Y rows and write one T column per PASS1 cycle.
    always_ff @(posedge clk) begin
        if (state == ST_LOAD && s_valid && s_ready) begin
            y_buf[row_cnt] <= s_row;
        end
        if (state == ST_PASS1) begin
            for (int unsigned i = 0; i < 4; i++) begin
                t_buf[i][col_cnt] <= p1_out[i*MID_W +: MID_W];
            end
        end
    end

    // Block sequencer with registered stream handshake outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_LOAD;
            row_cnt <= '0;
            col_cnt <= '0;
            s_ready <= 1'b1;
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_row   <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (s_valid) begin
                        if (row_cnt == 2'd3) begin
                            row_cnt <= '0;
                            col_cnt <= '0;
                            s_ready <= 1'b0;
                            state   <= ST_PASS1;
                        end else begin
                            row_cnt <= row_cnt + 2'd1;
                        end
                    end
                end
                ST_PASS1: begin
                    col_cnt <= col_cnt + 2'd1;
                    if (col_cnt == 2'd3) begin
                        state <= ST_OUT;
                    end
                end
                ST_OUT: begin
                    if (!m_valid) begin
                        m_row   <= p2_out;
                        m_valid <= 1'b1;
                        m_last  <= (row_cnt == 2'd3);
                    end else if (m_ready) begin
                        if (row_cnt == 2'd3) begin
                            row_cnt <= '0;
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            s_ready <= 1'b1;
                            state   <= ST_LOAD;
                        end else begin
                            row_cnt <= row_cnt + 2'd1;
                            m_row   <= p2_out;
                            m_last  <= (row_cnt == 2'd2);
                        end
                    end
                end
                default: begin
                    state   <= ST_LOAD;
                    row_cnt <= '0;
                    col_cnt <= '0;
                    s_ready <= 1'b1;
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_idst4x4_seq.sv
// Bench for idst4x4_seq: fixed vectors, random blocks with backpressure
// against a matrix-arithmetic reference, and a mid-block reset sequence.
module tb_idst4x4_seq;

    typedef int blk_t [4][4];
    typedef int row_t [4];

    typedef struct {
        string name;
        int    y00;
        int    yrest;
        row_t  r0;
        row_t  r3;
        row_t  r0n;
        row_t  r3n;
    } vec_t;

    localparam int MREF [4][4] = '{
        '{29, 55, 74, 84},
        '{74, 74, 0, -74},
        '{84, -29, -74, 55},
        '{55, -84, 74, -29}
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_valid;
    logic [63:0] s_row;
    logic        m_ready;
    logic        s_ready, m_valid, m_last;
    logic [63:0] m_row;
    logic        s_ready9, m_valid9, m_last9;
    logic [35:0] m_row9;

    int n_cmp = 0;
    int n_bad = 0;
    int acc_cnt = 0;

    logic [63:0] got16 [4];
    logic [35:0] got9  [4];
    vec_t        tab   [4];

    always #5 clk = ~clk;

    idst4x4_seq u_dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .s_row  (s_row),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .m_row  (m_row),
        .m_last (m_last)
    );

    idst4x4_seq #(.OUT_W(9)) u_dut9 (
        .clk    (clk),
        .rst_n  (rst_n),
        .s_valid(s_valid),
        .s_ready(s_ready9),
        .s_row  (s_row),
        .m_valid(m_valid9),
        .m_ready(m_ready),
        .m_row  (m_row9),
        .m_last (m_last9)
    );

    always @(posedge clk) begin
        if (rst_n && s_valid && s_ready) acc_cnt <= acc_cnt + 1;
    end

    initial begin
        #500us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_vec(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] pack16(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [35:0] pack9(input int a, input int b, input int c, input int d);
        return {9'(d), 9'(c), 9'(b), 9'(a)};
    endfunction

    function automatic longint clipv(input longint v, input int w);
        longint hi;
        hi = (longint'(1) <<< (w - 1)) - 1;
        if (v > hi) return hi;
        if (v < -hi - 1) return -hi - 1;
        return v;
    endfunction

    // Reference: T = clip20(round(M^T * Y >> 7)), X = clip(round(T * M >> 12)).
    function automatic void model(input blk_t y, output blk_t x16, output blk_t x9);
        longint t [4][4];
        longint acc;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                acc = 0;
                for (int k = 0; k < 4; k++) acc += longint'(MREF[k][i]) * y[k][j];
                t[i][j] = clipv((acc + 64) >>> 7, 20);
            end
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++) begin
                acc = 0;
                for (int k = 0; k < 4; k++) acc += t[i][k] * MREF[k][j];
                acc = (acc + 2048) >>> 12;
                x16[i][j] = int'(clipv(acc, 16));
                x9[i][j]  = int'(clipv(acc, 9));
            end
    endfunction

    task automatic check_reset_vals(input string tag);
        chk({tag, " s_ready"}, s_ready, 1);
        chk({tag, " m_valid"}, m_valid, 0);
        chk({tag, " m_last"}, m_last, 0);
        chk_vec({tag, " m_row"}, m_row, 64'd0);
        chk({tag, " s_ready9"}, s_ready9, 1);
        chk({tag, " m_valid9"}, m_valid9, 0);
        chk_vec({tag, " m_row9"}, 64'(m_row9), 64'd0);
    endtask

    // Called at a negedge; returns at the negedge after the last accept edge.
    task automatic send_rows(input blk_t y, input int nrows, input bit keep_valid);
        int guard;
        for (int r = 0; r < nrows; r++) begin
            s_row   = pack16(y[r][0], y[r][1], y[r][2], y[r][3]);
            s_valid = 1'b1;
            guard   = 0;
            while (!s_ready && guard < 64) begin
                @(negedge clk);
                guard++;
            end
            chk("load s_ready", s_ready, 1);
            if (!s_ready) begin
                s_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        if (keep_valid) begin
            s_row   = {$urandom, $urandom};
            s_valid = 1'b1;
        end else begin
            s_valid = 1'b0;
        end
    endtask

    task automatic recv_block(input int ready_pct);
        int          cyc;
        int          lat;
        bit          seen;
        bit          stalled;
        logic [63:0] held;
        logic        held_last;
        logic [35:0] held9;
        lat  = -1;
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            cyc     = 0;
            stalled = 0;
            held    = '0;
            held9   = '0;
            held_last = 1'b0;
            forever begin
                chk("busy s_ready", s_ready, 0);
                chk("busy s_ready9", s_ready9, 0);
                if (m_valid) begin
                    if (!seen) begin
                        seen = 1;
                        lat  = cyc;
                    end
                    if (stalled) begin
                        chk_vec("stall m_row", m_row, held);
                        chk("stall m_last", m_last, held_last);
                        chk_vec("stall m_row9", 64'(m_row9), 64'(held9));
                    end
                    m_ready = ($urandom_range(99) < ready_pct);
                    if (m_ready) break;
                    stalled   = 1;
                    held      = m_row;
                    held_last = m_last;
                    held9     = m_row9;
                end else begin
                    m_ready = 1'($urandom_range(1));
                end
                cyc++;
                if (cyc > 300) begin
                    chk("output timeout", 0, 1);
                    m_ready = 1'b0;
                    return;
                end
                @(negedge clk);
            end
            if (i == 0) chk("first row latency", lat, 5);
            else if (ready_pct >= 100) chk("back-to-back rows", cyc, 0);
            chk("m_last", m_last, (i == 3) ? 1 : 0);
            chk("dut9 m_valid", m_valid9, 1);
            chk("dut9 m_last", m_last9, (i == 3) ? 1 : 0);
            got16[i] = m_row;
            got9[i]  = m_row9;
            @(negedge clk);
        end
        m_ready = 1'b0;
        chk("s_ready after block", s_ready, 1);
        chk("m_valid after block", m_valid, 0);
    endtask

    task automatic compare_model(input string tag, input blk_t e16, input blk_t e9);
        for (int i = 0; i < 4; i++) begin
            chk_vec($sformatf("%s row%0d", tag, i), got16[i],
                    pack16(e16[i][0], e16[i][1], e16[i][2], e16[i][3]));
            chk_vec($sformatf("%s row%0d w9", tag, i), 64'(got9[i]),
                    64'(pack9(e9[i][0], e9[i][1], e9[i][2], e9[i][3])));
        end
    endtask

    initial begin
        blk_t y, e16, e9;
        int   a0;
        int   pct;
        int   mode;
        bit   keep;

        tab[0] = '{"zero", 0, 0, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}, '{0, 0, 0, 0}};
        tab[1] = '{"dc1024", 1024, 0, '{2, 3, 4, 5}, '{5, 9, 12, 14}, '{2, 3, 4, 5}, '{5, 9, 12, 14}};
        tab[2] = '{"allmax", 32767, 32767, '{3660, 242, 1119, 544}, '{545, 36, 167, 81},
                   '{255, 242, 255, 255}, '{255, 36, 167, 81}};
        tab[3] = '{"allmin", -32768, -32768, '{-3660, -242, -1119, -544}, '{-544, -36, -166, -81},
                   '{-256, -242, -256, -256}, '{-256, -36, -166, -81}};

        rst_n   = 1'b0;
        s_valid = 1'b0;
        s_row   = '0;
        m_ready = 1'b0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Fixed vectors with hand-derived rows 0 and 3.
        for (int v = 0; v < 4; v++) begin
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    y[r][c] = (r == 0 && c == 0) ? tab[v].y00 : tab[v].yrest;
            model(y, e16, e9);
            a0 = acc_cnt;
            send_rows(y, 4, 0);
            recv_block(100);
            chk({tab[v].name, " accepts"}, acc_cnt - a0, 4);
            chk_vec({tab[v].name, " row0"}, got16[0],
                    pack16(tab[v].r0[0], tab[v].r0[1], tab[v].r0[2], tab[v].r0[3]));
            chk_vec({tab[v].name, " row3"}, got16[3],
                    pack16(tab[v].r3[0], tab[v].r3[1], tab[v].r3[2], tab[v].r3[3]));
            chk_vec({tab[v].name, " row0 w9"}, 64'(got9[0]),
                    64'(pack9(tab[v].r0n[0], tab[v].r0n[1], tab[v].r0n[2], tab[v].r0n[3])));
            chk_vec({tab[v].name, " row3 w9"}, 64'(got9[3]),
                    64'(pack9(tab[v].r3n[0], tab[v].r3n[1], tab[v].r3n[2], tab[v].r3n[3])));
            compare_model(tab[v].name, e16, e9);
        end

        // Random blocks, random backpressure, s_valid sometimes held high while busy.
        for (int b = 0; b < 100; b++) begin
            mode = int'($urandom_range(2));
            for (int r = 0; r < 4; r++)
                for (int c = 0; c < 4; c++)
                    case (mode)
                        0:       y[r][c] = int'($urandom_range(65535)) - 32768;
                        1:       y[r][c] = int'($urandom_range(600)) - 300;
                        default: y[r][c] = ($urandom_range(1) != 0) ? 32767 : -32768;
                    endcase
            model(y, e16, e9);
            pct  = int'($urandom_range(100, 20));
            keep = 1'($urandom_range(1));
            a0   = acc_cnt;
            send_rows(y, 4, keep);
            recv_block(pct);
            chk("random accepts", acc_cnt - a0, 4);
            compare_model($sformatf("rand%0d", b), e16, e9);
        end

        // Reset after two accepted rows, then a complete DC block.
        s_valid = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                y[r][c] = int'($urandom_range(2000)) - 1000;
        send_rows(y, 2, 0);
        rst_n = 1'b0;
        #1;
        check_reset_vals("midblock reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                y[r][c] = (r == 0 && c == 0) ? 1024 : 0;
        model(y, e16, e9);
        a0 = acc_cnt;
        send_rows(y, 4, 0);
        recv_block(100);
        chk("post-reset accepts", acc_cnt - a0, 4);
        chk_vec("post-reset row0", got16[0], pack16(2, 3, 4, 5));
        chk_vec("post-reset row3", got16[3], pack16(5, 9, 12, 14));
        compare_model("post-reset", e16, e9);

        s_valid = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
